// File: rtl/store_pkg.sv
// Shared types and encodings for the store commit stage.
// State enum, store size encodings and default exception numbers.
package store_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_BYTE    = 2'd0;
    localparam logic [1:0] SIZE_HALF    = 2'd1;
    localparam logic [1:0] SIZE_WORD    = 2'd2;
    localparam logic [1:0] SIZE_ILLEGAL = 2'd3;

    localparam logic [5:0] EXC_STORE_MISALIGNED = 6'd6;
    localparam logic [5:0] EXC_STORE_FAULT      = 6'd7;

endpackage

// File: rtl/store_commit_if.sv
// Word-wide data-memory write port between the store commit stage and memory.
interface store_commit_if;

    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ack;
    logic        mem_err;

    modport master (
        output mem_req, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ack, mem_err
    );

    modport slave (
        input  mem_req, mem_addr, mem_wdata, mem_wstrb,
        output mem_ack, mem_err
    );

endinterface

// File: rtl/store_lane_align.sv
// Places a byte/half/word store value onto the 32-bit bus lanes and
// produces the matching byte strobes plus an alignment/size legality flag.
module store_lane_align
    import store_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic [31:0] val,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        misaligned
);

    always_comb begin
        wdata      = val;
        wstrb      = 4'b0000;
        misaligned = 1'b0;
        case (size)
            SIZE_BYTE: begin
                wdata = {4{val[7:0]}};
                wstrb = 4'b0001 << addr_lo;
            end
            SIZE_HALF: begin
                wdata      = {2{val[15:0]}};
                wstrb      = 4'b0011 << addr_lo;
                misaligned = addr_lo[0];
            end
            SIZE_WORD: begin
                wstrb      = 4'b1111;
                misaligned = (addr_lo != 2'b00);
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_commit.sv
// Store commit stage: accepts one execute result at a time, performs the
// data-memory write for legal stores and forwards results to writeback.
module store_commit
    import store_pkg::*;
#(
    parameter int         ACK_TIMEOUT          = 255,
    parameter logic [5:0] STORE_MISALIGNED_EXC = EXC_STORE_MISALIGNED,
    parameter logic [5:0] STORE_FAULT_EXC      = EXC_STORE_FAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,

    input  logic        ex_valid,
    output logic        ex_stall,
    input  logic [4:0]  ex_rd,
    input  logic [31:0] ex_rd_val,
    input  logic [31:0] ex_inst_pc,
    input  logic [31:0] ex_jump_pc,
    input  logic        ex_jump,
    input  logic [5:0]  ex_exception_num,
    input  logic [31:0] ex_exception_val,
    input  logic        ex_exception_valid,
    input  logic [31:0] ex_store_addr,
    input  logic [31:0] ex_store_val,
    input  logic [1:0]  ex_store_size,
    input  logic        ex_store_valid,

    store_commit_if.master mem,

    output logic        valid,
    input  logic        stall,
    output logic [4:0]  rd_out,
    output logic [31:0] rd_val_out,
    output logic [31:0] inst_pc_out,
    output logic [31:0] jump_pc_out,
    output logic        jump_out,
    output logic [5:0]  exception_num_out,
    output logic [31:0] exception_val_out,
    output logic        exception_valid_out
);

    localparam int CW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    state_t         state;
    logic [CW-1:0]  ack_cnt;
    logic [31:0]    store_addr_q;

    logic [31:0]    lane_wdata;
    logic [3:0]     lane_wstrb;
    logic           lane_misaligned;
    logic           accept;
    logic           store_go;
    logic           store_bad;
    logic           timeout_hit;

    store_lane_align u_lane_align (
        .addr_lo    (ex_store_addr[1:0]),
        .size       (ex_store_size),
        .val        (ex_store_val),
        .wdata      (lane_wdata),
        .wstrb      (lane_wstrb),
        .misaligned (lane_misaligned)
    );

    assign accept      = ex_valid && !flush && ((state == EMPTY) || (state == DONE && !stall));
    assign ex_stall    = (state == ISSUE) || (state == DRAIN) || (state == DONE && stall);
    assign store_go    = ex_store_valid && !ex_exception_valid && !lane_misaligned;
    assign store_bad   = ex_store_valid && !ex_exception_valid && lane_misaligned;
    // The counter reads ACK_TIMEOUT-1 during the last cycle the request may stay up.
    assign timeout_hit = (ACK_TIMEOUT != 0) && (ack_cnt == CW'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state               <= EMPTY;
            valid               <= 1'b0;
            mem.mem_req         <= 1'b0;
            mem.mem_addr        <= '0;
            mem.mem_wdata       <= '0;
            mem.mem_wstrb       <= '0;
            ack_cnt             <= '0;
            store_addr_q        <= '0;
            rd_out              <= '0;
            rd_val_out          <= '0;
            inst_pc_out         <= '0;
            jump_pc_out         <= '0;
            jump_out            <= 1'b0;
            exception_num_out   <= '0;
            exception_val_out   <= '0;
            exception_valid_out <= 1'b0;
        end else begin
            case (state)
                EMPTY, DONE: begin
                    if (accept) begin
                        rd_out              <= ex_rd;
                        rd_val_out          <= ex_rd_val;
                        inst_pc_out         <= ex_inst_pc;
                        jump_pc_out         <= ex_jump_pc;
                        jump_out            <= ex_jump;
                        exception_num_out   <= ex_exception_num;
                        exception_val_out   <= ex_exception_val;
                        exception_valid_out <= ex_exception_valid;
                        store_addr_q        <= ex_store_addr;
                        ack_cnt             <= '0;
                        if (store_go) begin
                            state         <= ISSUE;
                            valid         <= 1'b0;
                            mem.mem_req   <= 1'b1;
                            mem.mem_addr  <= {ex_store_addr[31:2], 2'b00};
                            mem.mem_wdata <= lane_wdata;
                            mem.mem_wstrb <= lane_wstrb;
                        end else begin
                            state <= DONE;
                            valid <= 1'b1;
                            if (store_bad) begin
                                exception_valid_out <= 1'b1;
                                exception_num_out   <= STORE_MISALIGNED_EXC;
                                exception_val_out   <= ex_store_addr;
                            end
                        end
                    end else if (flush || (state == DONE && !stall)) begin
                        state <= EMPTY;
                        valid <= 1'b0;
                    end
                end
                // A killed entry still waits for its bus transaction to end.
                ISSUE, DRAIN: begin
                    if (mem.mem_ack || timeout_hit) begin
                        mem.mem_req <= 1'b0;
                        if (flush || state == DRAIN) begin
                            state <= EMPTY;
                            valid <= 1'b0;
                        end else begin
                            state <= DONE;
                            valid <= 1'b1;
                            if (!mem.mem_ack || mem.mem_err) begin
                                exception_valid_out <= 1'b1;
                                exception_num_out   <= STORE_FAULT_EXC;
                                exception_val_out   <= store_addr_q;
                            end
                        end
                    end else begin
                        ack_cnt <= ack_cnt + CW'(1);
                        if (flush) begin
                            state <= DRAIN;
                        end
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

endmodule

// File: doc/store_commit.md
Name: store_commit

Overview:
- Consumer end of the execute-stage result interface. Takes one retired execute result per valid/stall handshake.
- For stores, performs the word-bus write transaction: lane alignment, byte strobes, request/acknowledge, timeout.
- Forwards rd/jump/exception results to writeback through its own valid/stall handshake.
- Sits between execute and writeback. It is the only block that drives the data-memory write port.

Parameters:
- ACK_TIMEOUT, 255: cycles mem_req may stay high without mem_ack before a store access fault is forced; 0 disables the timeout.
- STORE_MISALIGNED_EXC, 6: exception number for a misaligned or illegal-size store.
- STORE_FAULT_EXC, 7: exception number for a bus error or timeout.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-low; 0 resets all state immediately
- flush  in  1  kill the held entry; discard any input on the same cycle
- ex_valid  in  1  execute result present
- ex_stall  out  1  back-pressure to execute
- ex_rd  in  5 ; ex_rd_val  in  32 ; ex_inst_pc  in  32 ; ex_jump_pc  in  32 ; ex_jump  in  1
- ex_exception_num  in  6 ; ex_exception_val  in  32 ; ex_exception_valid  in  1
- ex_store_addr  in  32 ; ex_store_val  in  32 ; ex_store_size  in  2 (0 byte, 1 half, 2 word, 3 illegal) ; ex_store_valid  in  1
- mem_req  out  1 ; mem_addr  out  32 (word aligned) ; mem_wdata  out  32 ; mem_wstrb  out  4
- mem_ack  in  1 ; mem_err  in  1 (sampled only together with mem_ack)
- valid  out  1 ; stall  in  1  writeback handshake
- rd_out 5, rd_val_out 32, inst_pc_out 32, jump_pc_out 32, jump_out 1, exception_num_out 6, exception_val_out 32, exception_valid_out 1  (all out)

Behaviour:
- Reset: state EMPTY; valid, mem_req, mem_wstrb, jump_out, exception_valid_out all 0; every other output 0.
- States:
  - EMPTY: nothing held.
  - ISSUE: store request outstanding.
  - DRAIN: request outstanding, entry already killed.
  - DONE: result held; valid = 1.
- Accept condition: ex_valid && !flush && (EMPTY || (DONE && !stall)). ex_stall = ISSUE || DRAIN || (DONE && stall).
- On accept, all inputs are captured into the entry.
  - A store goes to ISSUE only if ex_store_valid && !ex_exception_valid && legal.
  - Legal means: size != 3; half requires addr[0] = 0; word requires addr[1:0] = 0.
  - An illegal store goes to DONE with exception_valid = 1, num = STORE_MISALIGNED_EXC, val = store_addr. No bus activity.
  - Non-store entries and entries with an incoming exception go to DONE unchanged. Latency is 1 cycle.
- ISSUE:
  - Drives mem_req = 1, mem_addr = {addr[31:2], 2'b00}.
  - mem_wdata: val replicated (byte → 4 copies, half → 2 copies, word → as is).
  - mem_wstrb: byte → 1 << addr[1:0]; half → 4'b0011 << addr[1:0]; word → 4'b1111.
  - All bus outputs stay stable until mem_ack.
  - mem_ack is honoured in the first cycle mem_req is high. mem_ack while mem_req = 0 is ignored.
  - On mem_ack && !mem_err → DONE, and mem_req drops the next cycle.
  - On mem_ack && mem_err → DONE with exception num STORE_FAULT_EXC, val = store_addr.
- Timeout:
  - A counter clears on entry to ISSUE and increments each cycle without ack.
  - When it reaches ACK_TIMEOUT, mem_req drops and the entry goes to DONE with STORE_FAULT_EXC.
  - A late ack after that point is ignored.
- Flush:
  - EMPTY/DONE → EMPTY; valid falls the next cycle.
  - ISSUE → DRAIN. The bus transaction is never abandoned: mem_req holds until ack or timeout, then → EMPTY with no valid.
  - Flush in DRAIN has no further effect.
- DONE && !stall without a new accept → EMPTY. Back-to-back accepts give 1 result per cycle for non-stores.
- Asynchronous reset mid-transaction drops mem_req immediately. The memory side tolerates this.

Decomposition:
- Package store_pkg holds:
  - state enum {EMPTY, ISSUE, DRAIN, DONE}
  - store size encodings (SIZE_BYTE/HALF/WORD)
  - default exception numbers
- One combinational sub-module, store_lane_align: (addr[1:0], size, val) → wdata, wstrb, misaligned. Reused later by load-side alignment.

Test Plan:
- Non-store ex_rd = 5, rd_val = 0x1234, stall = 0 → valid = 1 next cycle, rd_out = 5, rd_val_out = 0x1234; mem_req never high.
- Byte store addr 0x1003, val 0xAB, mem_ack same cycle as req → mem_addr = 0x1000, wdata = 0xABABABAB, wstrb = 4'b1000, valid 1 cycle after ack, exception_valid_out = 0.
- Half store addr 0x2001 → no mem_req; exception_valid_out = 1, num = 6, val = 0x2001.
- Word store addr 0x3000 with ack delayed 3 cycles and mem_err = 1 → bus signals stable 4 cycles, ex_stall high throughout, exception num 7, val = 0x3000.
- ACK_TIMEOUT = 4, no ack → mem_req high exactly 4 cycles, then exception num 7; a late ack is ignored.
- Flush during ISSUE, then ack 2 cycles later → mem_req held until ack, valid never asserts, next ex_valid accepted the cycle after ack. Also: reset = 0 mid-ISSUE → mem_req = 0 immediately.
